// File: rtl/bcd2bin_seq_pkg.sv
// ---------------------------------------------------------------------------
// bcd2bin_seq_pkg
//   Shared definitions for the sequential BCD-to-binary converter family:
//   FSM state encoding, the largest legal BCD digit, recommended output
//   widths per digit count and a helper that computes the minimum lossless
//   output width for a given number of digits.
// ---------------------------------------------------------------------------
package bcd2bin_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Minimum output widths that hold 10^DIGITS - 1 without wrapping.
    localparam int unsigned BIN_W_D1 = 4;
    localparam int unsigned BIN_W_D2 = 7;
    localparam int unsigned BIN_W_D3 = 10;
    localparam int unsigned BIN_W_D4 = 14;
    localparam int unsigned BIN_W_D8 = 27;

    // Bits needed to represent 10^digits - 1 (valid for digits <= 18).
    function automatic int unsigned bin_w_min(input int unsigned digits);
        longint unsigned top;
        int unsigned     bits;
        top  = 64'd1;
        bits = 0;
        for (int unsigned i = 0; i < digits; i++) begin
            top = top * 64'd10;
        end
        top = top - 64'd1;
        while (top != 64'd0) begin
            top  = top >> 1;
            bits = bits + 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/bcd2bin_seq_if.sv
// ---------------------------------------------------------------------------
// bcd2bin_seq_if
//   Handshake bundle between a BCD source, the converter and a binary
//   consumer.
//   Signals:
//     in_valid   source -> converter   bcd_in holds a word to convert
//     in_ready   converter -> source   converter can accept a word
//     bcd_in     source -> converter   packed BCD, digit 0 in bits [3:0]
//     out_valid  converter -> sink     bin_out/err are valid
//     out_ready  sink -> converter     sink accepts the result
//     bin_out    converter -> sink     binary result
//     err        converter -> sink     some nibble of the word was > 9
//   Modports:
//     master  the side that supplies words and consumes results
//     slave   the converter itself
// ---------------------------------------------------------------------------
interface bcd2bin_seq_if #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned BIN_W  = 14
);

    logic                  in_valid;
    logic                  in_ready;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [BIN_W-1:0]      bin_out;
    logic                  err;

    modport master (
        output in_valid,
        output bcd_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  bin_out,
        input  err
    );

    modport slave (
        input  in_valid,
        input  bcd_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output bin_out,
        output err
    );

endinterface

// File: rtl/bcd2bin_seq_step.sv
// ---------------------------------------------------------------------------
// bcd_digit_step
//   One Horner step of BCD-to-binary conversion: acc_next = acc*10 + d,
//   truncated to BIN_W bits. The multiply by ten is built from two shifts
//   and an add. Nibbles above 9 are used at their raw value and flagged.
//   Purely combinational so it can be chained for an unrolled converter.
//   Ports:
//     acc       running binary value
//     d         next BCD nibble (most significant remaining digit)
//     acc_next  acc*10 + d modulo 2^BIN_W
//     bad       d is not a legal BCD digit
// ---------------------------------------------------------------------------
module bcd_digit_step
    import bcd2bin_seq_pkg::*;
#(
    parameter int unsigned BIN_W = 14
) (
    input  logic [BIN_W-1:0] acc,
    input  logic [3:0]       d,
    output logic [BIN_W-1:0] acc_next,
    output logic             bad
);

    logic [BIN_W-1:0] acc_x8;
    logic [BIN_W-1:0] acc_x2;
    logic [BIN_W-1:0] digit_ext;

    always_comb begin
        acc_x8    = acc << 3;
        acc_x2    = acc << 1;
        digit_ext = BIN_W'(d);
        acc_next  = acc_x8 + acc_x2 + digit_ext;
        bad       = (d > BCD_MAX);
    end

endmodule

// File: rtl/bcd2bin_seq.sv
// ---------------------------------------------------------------------------
// bcd2bin_seq
//   Sequential packed-BCD to unsigned binary converter. A DIGITS-digit word
//   is converted one digit per clock, most significant digit first, using
//   acc = acc*10 + digit. A word is accepted in IDLE, converted over DIGITS
//   CONV cycles and presented in DONE until the consumer takes it. err is
//   set if any nibble of the accepted word exceeded 9; the raw nibble value
//   still enters the arithmetic.
//   Parameters:
//     DIGITS  number of packed BCD digits (>= 1)
//     BIN_W   output width; narrower than the lossless width wraps
//     CNT_W   digit counter width, 2^CNT_W > DIGITS
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    handshake bundle (slave side): in_valid/in_ready/bcd_in,
//            out_valid/out_ready/bin_out/err
// ---------------------------------------------------------------------------
module bcd2bin_seq
    import bcd2bin_seq_pkg::*;
#(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned BIN_W  = BIN_W_D4,
    parameter int unsigned CNT_W  = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    bcd2bin_seq_if.slave  bus
);

    localparam int unsigned IN_W = 4 * DIGITS;

    state_t             state_q;
    state_t             state_d;

    logic [IN_W-1:0]    shreg_q;
    logic [BIN_W-1:0]   acc_q;
    logic               err_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               in_ready_c;
    logic               out_valid_c;
    logic               accept;

    logic [3:0]         digit;
    logic [BIN_W-1:0]   acc_next;
    logic               digit_bad;

    // The shift register moves left, so the next digit is always on top.
    assign digit = shreg_q[IN_W-1 -: 4];

    bcd_digit_step #(
        .BIN_W (BIN_W)
    ) u_step (
        .acc      (acc_q),
        .d        (digit),
        .acc_next (acc_next),
        .bad      (digit_bad)
    );

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next-state and handshake outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                // cnt_q == 1 means the digit being consumed now is the last.
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign accept = (state_q == ST_IDLE) && bus.in_valid;

    // -----------------------------------------------------------------------
    // Datapath: shift register, accumulator, sticky error, digit counter.
    // acc/err are left untouched outside CONV so the last result stays on
    // bin_out until the next word is accepted.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
            acc_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else if (accept) begin
            shreg_q <= bus.bcd_in;
            acc_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= CNT_W'(DIGITS);
        end else if (state_q == ST_CONV) begin
            shreg_q <= shreg_q << 4;
            acc_q   <= acc_next;
            err_q   <= err_q | digit_bad;
            cnt_q   <= cnt_q - CNT_W'(1);
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.bin_out   = acc_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// ---------------------------------------------------------------------------
// tb_bcd2bin_seq
//   Self-checking bench for bcd2bin_seq: a 4-digit/14-bit instance (A) and a
//   2-digit/7-bit instance (B). Expected results are queued at accept time
//   and compared at each output handshake, together with the latency.
// ---------------------------------------------------------------------------
module tb_bcd2bin_seq;

    logic clk;
    logic rst_n_a;
    logic rst_n_b;

    bcd2bin_seq_if #(.DIGITS(4), .BIN_W(14)) ifa ();
    bcd2bin_seq_if #(.DIGITS(2), .BIN_W(7))  ifb ();

    bcd2bin_seq #(.DIGITS(4), .BIN_W(14), .CNT_W(3)) dut_a (
        .clk   (clk),
        .rst_n (rst_n_a),
        .bus   (ifa.slave)
    );

    bcd2bin_seq #(.DIGITS(2), .BIN_W(7), .CNT_W(2)) dut_b (
        .clk   (clk),
        .rst_n (rst_n_b),
        .bus   (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] bcd;
        int unsigned exp_bin;
        bit          exp_err;
    } vec_t;

    typedef struct {
        int unsigned bin;
        bit          err;
        int          acc;
        bit          chk_lat;
    } sb_t;

    localparam int NA = 10;

    vec_t        tbl_a [NA];
    sb_t         sb_a [$];
    sb_t         sb_b [$];

    int          tests = 0;
    int          fails = 0;
    int          cycle = 0;

    int unsigned cur_bin_a = 0;
    bit          cur_err_a = 1'b0;
    int unsigned cur_bin_b = 0;
    bit          cur_err_b = 1'b0;
    bit          push_en_a = 1'b1;
    bit          lat_chk   = 1'b1;

    function automatic void check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    // One clock: sample handshakes just before the edge, advance to 1 time
    // unit after it, then update the scoreboards.
    task automatic tick();
        bit          acc_a;
        bit          hs_a;
        bit          acc_b;
        bit          hs_b;
        int unsigned bo_a;
        int unsigned bo_b;
        bit          e_a;
        bit          e_b;
        sb_t         e;
        acc_a = ifa.in_valid && ifa.in_ready;
        hs_a  = ifa.out_valid && ifa.out_ready;
        bo_a  = 32'(ifa.bin_out);
        e_a   = ifa.err;
        acc_b = ifb.in_valid && ifb.in_ready;
        hs_b  = ifb.out_valid && ifb.out_ready;
        bo_b  = 32'(ifb.bin_out);
        e_b   = ifb.err;
        @(posedge clk);
        #1;
        cycle++;
        if (acc_a && push_en_a) sb_a.push_back('{cur_bin_a, cur_err_a, cycle, lat_chk});
        if (acc_b) sb_b.push_back('{cur_bin_b, cur_err_b, cycle, 1'b1});
        if (hs_a) begin
            if (sb_a.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_out_a: got bin_out %0d err %0d, expected no output", bo_a, e_a);
            end else begin
                e = sb_a.pop_front();
                check("bin_a", bo_a, e.bin);
                check("err_a", e_a, e.err);
                if (e.chk_lat) check("lat_a", cycle - e.acc, 5);
            end
        end
        if (hs_b) begin
            if (sb_b.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_out_b: got bin_out %0d err %0d, expected no output", bo_b, e_b);
            end else begin
                e = sb_b.pop_front();
                check("bin_b", bo_b, e.bin);
                check("err_b", e_b, e.err);
                check("lat_b", cycle - e.acc, 3);
            end
        end
    endtask

    task automatic send_a(input logic [15:0] bcd, input int unsigned eb, input bit ee);
        int n;
        n = 0;
        ifa.bcd_in   = bcd;
        cur_bin_a    = eb;
        cur_err_a    = ee;
        ifa.in_valid = 1'b1;
        while (!ifa.in_ready && n < 50) begin
            tick();
            n++;
        end
        check("send_a_ready", ifa.in_ready, 1);
        if (ifa.in_ready) tick();
        ifa.in_valid = 1'b0;
    endtask

    task automatic wait_valid_a();
        int n;
        n = 0;
        while (!ifa.out_valid && n < 50) begin
            tick();
            n++;
        end
    endtask

    task automatic drain_a();
        int n;
        n = 0;
        while (sb_a.size() > 0 && n < 100) begin
            tick();
            n++;
        end
        check("drain_a", sb_a.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int idx;
        int n;
        int last;
        int c0;
        bit seen;
        bit pre;

        tbl_a[0] = '{16'h9999, 9999, 1'b0};
        tbl_a[1] = '{16'h0000, 0,    1'b0};
        tbl_a[2] = '{16'h12A4, 1304, 1'b1};
        tbl_a[3] = '{16'h0042, 42,   1'b0};
        tbl_a[4] = '{16'h0001, 1,    1'b0};
        tbl_a[5] = '{16'h9000, 9000, 1'b0};
        tbl_a[6] = '{16'h0909, 909,  1'b0};
        tbl_a[7] = '{16'hFFFF, 281,  1'b1};
        tbl_a[8] = '{16'h1A00, 2000, 1'b1};
        tbl_a[9] = '{16'h0100, 100,  1'b0};

        rst_n_a       = 1'b0;
        rst_n_b       = 1'b0;
        ifa.in_valid  = 1'b0;
        ifa.bcd_in    = '0;
        ifa.out_ready = 1'b1;
        ifb.in_valid  = 1'b0;
        ifb.bcd_in    = '0;
        ifb.out_ready = 1'b1;

        // Reset state
        repeat (3) tick();
        check("rst_in_ready", ifa.in_ready, 1);
        check("rst_out_valid", ifa.out_valid, 0);
        check("rst_bin_out", ifa.bin_out, 0);
        check("rst_err", ifa.err, 0);
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;
        tick();
        check("idle_in_ready", ifa.in_ready, 1);

        // Single word, latency to out_valid and ready afterwards
        send_a(16'h1234, 1234, 1'b0);
        c0 = cycle;
        wait_valid_a();
        check("lat_1234", cycle - c0, 4);
        check("bin_1234_pre", ifa.bin_out, 1234);
        tick();
        check("ready_after_1234", ifa.in_ready, 1);
        check("sb_a_after_1234", sb_a.size(), 0);

        // Table stream, in_valid held so accepts run at the initiation interval
        idx  = 0;
        n    = 0;
        last = -1;
        ifa.bcd_in   = tbl_a[0].bcd;
        cur_bin_a    = tbl_a[0].exp_bin;
        cur_err_a    = tbl_a[0].exp_err;
        ifa.in_valid = 1'b1;
        while (idx < NA && n < 500) begin
            pre = ifa.in_ready;
            tick();
            n++;
            if (pre) begin
                if (idx > 0) check("ii_a", cycle - last, 6);
                last = cycle;
                idx++;
                if (idx < NA) begin
                    ifa.bcd_in = tbl_a[idx].bcd;
                    cur_bin_a  = tbl_a[idx].exp_bin;
                    cur_err_a  = tbl_a[idx].exp_err;
                end
            end
        end
        ifa.in_valid = 1'b0;
        check("stream_a_count", idx, NA);
        drain_a();

        // Backpressure: result held, input ignored while not ready
        lat_chk       = 1'b0;
        ifa.out_ready = 1'b0;
        send_a(16'h0063, 63, 1'b0);
        wait_valid_a();
        check("bp_valid", ifa.out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            ifa.in_valid = 1'b1;
            ifa.bcd_in   = 16'($urandom);
            tick();
            check("bp_hold_valid", ifa.out_valid, 1);
            check("bp_hold_bin", ifa.bin_out, 63);
            check("bp_hold_err", ifa.err, 0);
            check("bp_in_ready", ifa.in_ready, 0);
        end
        ifa.in_valid  = 1'b0;
        ifa.out_ready = 1'b1;
        tick();
        check("bp_sb_empty", sb_a.size(), 0);
        check("idle_hold_bin", ifa.bin_out, 63);
        check("bp_ready_after", ifa.in_ready, 1);
        lat_chk = 1'b1;

        // Reset during the second CONV cycle discards the word
        push_en_a = 1'b0;
        send_a(16'h5678, 0, 1'b0);
        tick();
        rst_n_a = 1'b0;
        #1;
        check("mid_rst_in_ready", ifa.in_ready, 1);
        check("mid_rst_out_valid", ifa.out_valid, 0);
        check("mid_rst_bin_out", ifa.bin_out, 0);
        check("mid_rst_err", ifa.err, 0);
        tick();
        rst_n_a = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (ifa.out_valid) seen = 1'b1;
        end
        check("no_valid_after_rst", seen, 0);
        push_en_a = 1'b1;
        send_a(16'h0010, 10, 1'b0);
        drain_a();

        // Instance B: sweep all valid two-digit codes back to back
        idx  = 0;
        n    = 0;
        last = -1;
        ifb.bcd_in   = 8'h00;
        cur_bin_b    = 0;
        cur_err_b    = 1'b0;
        ifb.in_valid = 1'b1;
        while (idx < 100 && n < 1000) begin
            pre = ifb.in_ready;
            tick();
            n++;
            if (pre) begin
                if (idx > 0) check("ii_b", cycle - last, 4);
                last = cycle;
                idx++;
                if (idx < 100) begin
                    ifb.bcd_in = {4'(idx / 10), 4'(idx % 10)};
                    cur_bin_b  = idx;
                    cur_err_b  = 1'b0;
                end
            end
        end
        ifb.in_valid = 1'b0;
        check("stream_b_count", idx, 100);
        n = 0;
        while (sb_b.size() > 0 && n < 100) begin
            tick();
            n++;
        end
        check("drain_b", sb_b.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bcd2bin_seq.md
Name: bcd2bin_seq

Overview:
Parametrised, sequential successor to the fixed 2-digit combinational BCD-to-binary converter. Converts a DIGITS-digit packed BCD word to unsigned binary iteratively, one digit per clock, most-significant digit first, using acc = acc*10 + digit. Valid/ready handshakes on input and output, plus a per-word invalid-digit error flag. Sits between BCD sources (keypad/display/RTC registers) and binary datapath logic.

Parameters:
DIGITS, 4, number of packed BCD digits in the input word (>=1)
BIN_W, 14, output width; must be >= ceil(DIGITS*log2(10)) (DIGITS=2 -> 7, 3 -> 10, 4 -> 14, 8 -> 27); smaller values give the result modulo 2^BIN_W
CNT_W, 3, digit counter width; must satisfy 2^CNT_W > DIGITS

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  bcd_in holds a word to convert
in_ready  output  1  block can accept a word
bcd_in  input  4*DIGITS  packed BCD, digit k in bits [4k+3:4k], digit 0 is the units digit
out_valid  output  1  bin_out/err are valid
out_ready  input  1  consumer accepts the result
bin_out  output  BIN_W  binary result
err  output  1  at least one nibble of the accepted word was > 9

Behaviour:
- Reset is asynchronous active-low (rst_n low), on a single clock clk. During and after reset: state IDLE, in_ready=1, out_valid=0, bin_out=0, err=0, counter=0, shift register=0.
- FSM states:
  - IDLE: in_ready=1. If in_valid, latch bcd_in into the shift register, clear acc and err, load counter=DIGITS, go to CONV.
  - CONV: in_ready=0, out_valid=0. Each cycle, take the top nibble d of the shift register and set acc <= acc*10 + d (acc*10 formed as (acc<<3)+(acc<<1), truncated to BIN_W). Set err <= err | (d>9). Shift the register left by 4 and decrement the counter. When the counter reaches 1 on this step, go to DONE.
  - DONE: out_valid=1, in_ready=0. bin_out and err are stable. If out_ready, go to IDLE.
- Latency:
  - Input accepted on edge T; out_valid is high after edge T+DIGITS.
  - Minimum initiation interval is DIGITS+2 cycles. There is no accept in the same cycle as the output handshake.
- Invalid digit:
  - The nibble is used at its raw value (10..15) in the MAC; no saturation.
  - err=1 is reported with the result.
  - err is sticky for that word only and cleared on the next accept.
- Backpressure: out_ready low in DONE holds bin_out/err/out_valid indefinitely with no change.
- Input changes while in_ready=0 are ignored. bcd_in is sampled only on the accept edge.
- DIGITS=1: single CONV cycle, bin_out = digit.
- rst_n asserted mid-CONV or in DONE: immediate return to reset values. The partial result is discarded and no out_valid pulse is produced.
- bin_out holds its last value after returning to IDLE until the next accept clears acc.

Decomposition:
- Shared include/package holds:
  - FSM state encodings: ST_IDLE=2'd0, ST_CONV=2'd1, ST_DONE=2'd2.
  - BCD_MAX=4'd9.
  - Recommended BIN_W values per DIGITS.
- One combinational sub-module, bcd_digit_step, is natural.
  - Inputs: acc[BIN_W], d[4]. Outputs: acc_next = acc*10+d, bad = (d>9).
  - It is reused by a future fully unrolled variant.

Test Plan:
- DIGITS=4, bcd_in=16'h1234, out_ready=1 -> out_valid 4 cycles after accept, bin_out=14'd1234 (0x04D2), err=0, then in_ready=1 the following cycle.
- bcd_in=16'h9999 then 16'h0000 back-to-back with in_valid held -> bin_out=9999 (0x270F), then 0, err=0 both times, second accept exactly DIGITS+2 cycles after the first.
- bcd_in=16'h12A4 -> err=1, bin_out=1304. Next word 16'h0042 -> err=0, bin_out=42.
- out_ready low for 5 cycles after out_valid on 16'h0063 -> bin_out=63 held, in_ready=0 throughout; bcd_in toggled meanwhile has no effect.
- rst_n pulsed low for 1 cycle during the 2nd CONV cycle of 16'h5678 -> out_valid never rises for that word; outputs are 0 and in_ready=1 immediately; the next word 16'h0010 yields 10.
- DIGITS=2, BIN_W=7 instance: sweep all 100 valid codes 00..99 -> bin_out equals the decimal value, err=0, latency 2.
